// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of mem_arbiter bundled as one interface.
// The slave modport is the arbiter's view; master is the pipeline/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              d_req;
    logic              f_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              f_ready;
    logic [DATA_W-1:0] d_rdata;
    logic [DATA_W-1:0] f_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              grant;

    modport slave (
        input  d_req, f_req, d_we, d_addr, f_addr, d_wdata, ram_rdata,
        output d_ready, f_ready, d_rdata, f_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy, grant
    );

    modport master (
        output d_req, f_req, d_we, d_addr, f_addr, d_wdata, ram_rdata,
        input  d_ready, f_ready, d_rdata, f_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (D load/store, F fetch) arbiter for the single-port data RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed D priority.
module mem_arbiter #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              grant_r, grant_nxt;
    logic              we_r, we_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt;
    logic [DATA_W-1:0] f_rdata_r, f_rdata_nxt;
    logic              win_f;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_f, last_f_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_r   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            d_rdata_r <= '0;
            f_rdata_r <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_f    <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            grant_r   <= grant_nxt;
            we_r      <= we_nxt;
            addr_r    <= addr_nxt;
            wdata_r   <= wdata_nxt;
            d_rdata_r <= d_rdata_nxt;
            f_rdata_r <= f_rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_f    <= last_f_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        grant_nxt   = grant_r;
        we_nxt      = we_r;
        addr_nxt    = addr_r;
        wdata_nxt   = wdata_r;
        d_rdata_nxt = d_rdata_r;
        f_rdata_nxt = f_rdata_r;
        // Uncontested F wins; ties go to D unless round-robin flips them.
        win_f       = bus.f_req & ~bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
        last_f_nxt  = last_f;
        if (bus.d_req && bus.f_req) win_f = ~last_f;
`endif
        case (state)
            IDLE: begin
                if (bus.d_req || bus.f_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_INIT;
                    grant_nxt = win_f;
`ifdef ARB_ROUND_ROBIN_EN
                    last_f_nxt = win_f;
`endif
                    if (win_f) begin
                        we_nxt    = 1'b0;
                        addr_nxt  = bus.f_addr;
                        wdata_nxt = '0;
                    end else begin
                        we_nxt    = bus.d_we;
                        addr_nxt  = bus.d_addr;
                        wdata_nxt = bus.d_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    if (grant_r) f_rdata_nxt = bus.ram_rdata;
                    else         d_rdata_nxt = bus.ram_rdata;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ram_en    = (state == ACCESS);
    assign bus.ram_we    = (state == ACCESS) && we_r;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_wdata = wdata_r;
    assign bus.d_ready   = (state == RESP) && !grant_r;
    assign bus.f_ready   = (state == RESP) && grant_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.f_rdata   = f_rdata_r;
    assign bus.busy      = (state != IDLE);
    assign bus.grant     = grant_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter at LATENCY 2 (a), 1 (b) and 3 (c).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bc ();

    mem_arbiter #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut_a (.clk(clk), .reset(rst),   .bus(ba.slave));
    mem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_b (.clk(clk), .reset(rst),   .bus(bb.slave));
    mem_arbiter #(.LATENCY(3), .ADDR_W(32), .DATA_W(32)) dut_c (.clk(clk), .reset(rst_c), .bus(bc.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g [4];
        ba.d_req = 0; ba.f_req = 0; ba.d_we = 0; ba.d_addr = '0; ba.f_addr = '0; ba.d_wdata = '0; ba.ram_rdata = '0;
        bb.d_req = 0; bb.f_req = 0; bb.d_we = 0; bb.d_addr = '0; bb.f_addr = '0; bb.d_wdata = '0; bb.ram_rdata = '0;
        bc.d_req = 0; bc.f_req = 0; bc.d_we = 0; bc.d_addr = '0; bc.f_addr = '0; bc.d_wdata = '0; bc.ram_rdata = '0;
        tick(); tick();
        check("rst_busy", ba.busy, 0);
        check("rst_grant", ba.grant, 0);
        check("rst_ram_en", ba.ram_en, 0);
        check("rst_ram_addr", ba.ram_addr, 0);
        check("rst_d_rdata", ba.d_rdata, 0);
        rst = 0; rst_c = 0;
        tick();

        // F read, LATENCY=2
        ba.f_addr = 32'h10; ba.f_req = 1; ba.ram_rdata = 32'hDEADBEEF;
        check("t1_c0_ram_en", ba.ram_en, 0);
        tick();
        check("t1_c1_ram_en", ba.ram_en, 1);
        check("t1_c1_grant", ba.grant, 1);
        check("t1_c1_busy", ba.busy, 1);
        check("t1_c1_ram_addr", ba.ram_addr, 32'h10);
        check("t1_c1_ram_we", ba.ram_we, 0);
        tick();
        check("t1_c2_ram_en", ba.ram_en, 1);
        check("t1_c2_f_ready", ba.f_ready, 0);
        tick();
        check("t1_c3_f_ready", ba.f_ready, 1);
        check("t1_c3_f_rdata", ba.f_rdata, 32'hDEADBEEF);
        check("t1_c3_ram_en", ba.ram_en, 0);
        check("t1_c3_d_ready", ba.d_ready, 0);
        check("t1_c3_grant", ba.grant, 1);
        tick();
        ba.f_req = 0;
        check("t1_c4_f_ready", ba.f_ready, 0);
        check("t1_c4_busy", ba.busy, 0);
        tick();
        check("t1_c5_busy", ba.busy, 0);

        // D write; d_addr changes mid-access
        ba.d_req = 1; ba.d_we = 1; ba.d_addr = 32'h20; ba.d_wdata = 32'h12345678;
        tick();
        check("t2_c1_ram_we", ba.ram_we, 1);
        check("t2_c1_ram_addr", ba.ram_addr, 32'h20);
        check("t2_c1_ram_wdata", ba.ram_wdata, 32'h12345678);
        check("t2_c1_grant", ba.grant, 0);
        ba.d_addr = 32'h40;
        tick();
        check("t2_c2_ram_we", ba.ram_we, 1);
        check("t2_c2_ram_addr", ba.ram_addr, 32'h20);
        tick();
        check("t2_c3_d_ready", ba.d_ready, 1);
        check("t2_c3_f_ready", ba.f_ready, 0);
        check("t2_c3_ram_en", ba.ram_en, 0);
        check("t2_c3_ram_we", ba.ram_we, 0);
        tick();
        ba.d_req = 0; ba.d_we = 0;
        check("t2_c4_d_ready", ba.d_ready, 0);

        // Simultaneous requests, LATENCY=1
        bb.d_addr = 32'h4; bb.f_addr = 32'h8; bb.ram_rdata = 32'h55;
        bb.d_req = 1; bb.f_req = 1;
        tick();
        check("t3_c1_grant", bb.grant, 0);
        check("t3_c1_ram_addr", bb.ram_addr, 32'h4);
        tick();
        check("t3_c2_d_ready", bb.d_ready, 1);
        check("t3_c2_d_rdata", bb.d_rdata, 32'h55);
        check("t3_c2_f_ready", bb.f_ready, 0);
        tick();
        bb.d_req = 0;
        check("t3_c3_busy", bb.busy, 0);
        tick();
        check("t3_c4_grant", bb.grant, 1);
        check("t3_c4_ram_en", bb.ram_en, 1);
        check("t3_c4_ram_addr", bb.ram_addr, 32'h8);
        tick();
        check("t3_c5_f_ready", bb.f_ready, 1);
        check("t3_c5_d_ready", bb.d_ready, 0);
        tick();
        bb.f_req = 0;
        tick();

        // Continuous contention; last grant before this was F
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        bb.d_req = 1; bb.f_req = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_grant%0d", k), bb.grant, exp_g[k]);
            check($sformatf("t4_ram_en%0d", k), bb.ram_en, 1);
            tick();
            check($sformatf("t4_d_ready%0d", k), bb.d_ready, !exp_g[k]);
            check($sformatf("t4_f_ready%0d", k), bb.f_ready, exp_g[k]);
            tick();
            check($sformatf("t4_idle%0d", k), bb.busy, 0);
        end
        bb.d_req = 0; bb.f_req = 0;
        tick();

        // Reset in second ACCESS cycle, LATENCY=3
        bc.f_addr = 32'h30; bc.f_req = 1; bc.ram_rdata = 32'hA5A50003;
        tick();
        check("t5_c1_ram_en", bc.ram_en, 1);
        check("t5_c1_grant", bc.grant, 1);
        tick();
        rst_c = 1;
        check("t5_c2_ram_en", bc.ram_en, 1);
        tick();
        rst_c = 0;
        check("t5_c3_ram_en", bc.ram_en, 0);
        check("t5_c3_busy", bc.busy, 0);
        check("t5_c3_grant", bc.grant, 0);
        check("t5_c3_ram_addr", bc.ram_addr, 0);
        check("t5_c3_f_ready", bc.f_ready, 0);
        check("t5_c3_f_rdata", bc.f_rdata, 0);
        tick();
        check("t5_c4_ram_en", bc.ram_en, 1);
        check("t5_c4_ram_addr", bc.ram_addr, 32'h30);
        check("t5_c4_grant", bc.grant, 1);
        tick();
        tick();
        check("t5_c6_ram_en", bc.ram_en, 1);
        check("t5_c6_f_ready", bc.f_ready, 0);
        tick();
        check("t5_c7_f_ready", bc.f_ready, 1);
        check("t5_c7_f_rdata", bc.f_rdata, 32'hA5A50003);
        check("t5_c7_ram_en", bc.ram_en, 0);
        tick();
        bc.f_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
